// File: rtl/load_store_unit.sv
// load_store_unit
//   Handshaked load/store unit sitting between the MEM stage and a
//   req/gnt/rvalid data memory port. One access in flight at a time.
//   Generates byte enables and lane-replicated store data for word,
//   halfword and byte accesses; extracts and sign/zero-extends load data;
//   rejects misaligned accesses without touching the bus.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   data_req_o/gnt_i       bus request (held until grant) / grant
//   data_rvalid_i          bus response (load data or store completion)
//   data_addr_o            word-aligned bus address
//   data_we_o, data_be_o   store flag, byte enables
//   data_wdata_o           lane-replicated store data
//   data_rdata_i           raw bus read data
//   mem_req_i, mem_we_i    MEM-stage request and store flag
//   mem_data_type_i        00 word, 01 half, 10 byte, 11 treated as word
//   mem_sign_ext_i         sign-extend sub-word loads
//   mem_wdata_i            right-aligned store data
//   mem_addr_i             byte address
//   mem_rdata_o            extended load data, held until next load completes
//   mem_rvalid_o           one-cycle completion pulse
//   mem_busy_o             access in flight; pipeline must hold
//   mem_misaligned_o       one-cycle misaligned-reject pulse
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_data_type_i,
  input  logic                  mem_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_rvalid_o,
  output logic                  mem_busy_o,
  output logic                  mem_misaligned_o
);

  // Lane logic below is written for a 32-bit bus only.
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("load_store_unit: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RV = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            type_q, type_d;
  logic                  sign_q, sign_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  misal_q, misal_d;

  logic [3:0]            be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  misal_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  // Request decode: byte enables, lane replication and alignment check.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = mem_wdata_i;
    misal_s = 1'b0;
    case (mem_data_type_i)
      2'b01: begin
        be_s    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{mem_wdata_i[15:0]}};
        misal_s = mem_addr_i[0];
      end
      2'b10: begin
        be_s    = 4'b0001 << mem_addr_i[1:0];
        wdata_s = {4{mem_wdata_i[7:0]}};
        misal_s = 1'b0;
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = mem_wdata_i;
        misal_s = |mem_addr_i[1:0];
      end
    endcase
  end

  // Load extraction from the registered offset/type and sign/zero extension.
  always_comb begin
    case (off_q)
      2'd0:    byte_s = data_rdata_i[7:0];
      2'd1:    byte_s = data_rdata_i[15:8];
      2'd2:    byte_s = data_rdata_i[23:16];
      default: byte_s = data_rdata_i[31:24];
    endcase
    half_s = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (type_q)
      2'b01:   load_data_s = {{16{sign_q & half_s[15]}}, half_s};
      2'b10:   load_data_s = {{24{sign_q & byte_s[7]}}, byte_s};
      default: load_data_s = data_rdata_i;
    endcase
  end

  // Next-state and next-register logic of the access FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    type_d   = type_q;
    sign_d   = sign_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    misal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i && misal_s) begin
          misal_d = 1'b1;
          state_d = IDLE;
        end else if (mem_req_i) begin
          addr_d  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
          we_d    = mem_we_i;
          be_d    = be_s;
          wdata_d = wdata_s;
          type_d  = mem_data_type_i;
          sign_d  = mem_sign_ext_i;
          off_d   = mem_addr_i[1:0];
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // rvalid here would be a protocol violation and is ignored.
        if (data_gnt_i) begin
          state_d = WAIT_RV;
        end else begin
          state_d = REQ;
        end
      end
      WAIT_RV: begin
        if (data_rvalid_i) begin
          rvalid_d = 1'b1;
          state_d  = IDLE;
          if (!we_q) begin
            rdata_d = load_data_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = WAIT_RV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      type_q   <= 2'b00;
      sign_q   <= 1'b0;
      off_q    <= 2'b00;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      sign_q   <= sign_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      misal_q  <= misal_d;
    end
  end

  assign data_req_o       = (state_q == REQ);
  assign mem_busy_o       = (state_q != IDLE);
  assign data_addr_o      = addr_q;
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_wdata_o     = wdata_q;
  assign mem_rdata_o      = rdata_q;
  assign mem_rvalid_o     = rvalid_q;
  assign mem_misaligned_o = misal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed scenarios for load_store_unit; each task drives its own
//   stimulus and compares outputs against hand-computed values.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_data_type_i;
  logic        mem_sign_ext_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o;
  logic        mem_busy_o;
  logic        mem_misaligned_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_data_type_i(mem_data_type_i),
    .mem_sign_ext_i(mem_sign_ext_i), .mem_wdata_i(mem_wdata_i), .mem_addr_i(mem_addr_i),
    .mem_rdata_o(mem_rdata_o), .mem_rvalid_o(mem_rvalid_o), .mem_busy_o(mem_busy_o),
    .mem_misaligned_o(mem_misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [1:0] ty, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    mem_req_i = 1'b1; mem_we_i = we; mem_data_type_i = ty;
    mem_sign_ext_i = sg; mem_addr_i = addr; mem_wdata_i = wd;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    vec_cnt++; if (data_req_o !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %b exp 0", data_req_o); end
    vec_cnt++; if (mem_busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b exp 0", mem_busy_o); end
    vec_cnt++; if (data_addr_o !== 32'h0) begin err_cnt++; $display("FAIL rst_addr got %h exp 0", data_addr_o); end
    vec_cnt++; if (mem_rdata_o !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata got %h exp 0", mem_rdata_o); end
    vec_cnt++; if ({mem_rvalid_o, mem_misaligned_o, data_we_o} !== 3'b000) begin err_cnt++; $display("FAIL rst_flags got %b exp 000", {mem_rvalid_o, mem_misaligned_o, data_we_o}); end
  endtask

  task automatic test_byte_store();
    set_req(1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if (data_req_o !== 1'b1) begin err_cnt++; $display("FAIL bst_req got %b exp 1", data_req_o); end
    vec_cnt++; if (data_addr_o !== 32'h0000_1000) begin err_cnt++; $display("FAIL bst_addr got %h exp 00001000", data_addr_o); end
    vec_cnt++; if (data_be_o !== 4'b1000) begin err_cnt++; $display("FAIL bst_be got %b exp 1000", data_be_o); end
    vec_cnt++; if (data_wdata_o !== 32'hA5A5_A5A5) begin err_cnt++; $display("FAIL bst_wdata got %h exp a5a5a5a5", data_wdata_o); end
    vec_cnt++; if (data_we_o !== 1'b1) begin err_cnt++; $display("FAIL bst_we got %b exp 1", data_we_o); end
    tick();
    vec_cnt++; if (data_req_o !== 1'b0) begin err_cnt++; $display("FAIL bst_req_drop got %b exp 0", data_req_o); end
    vec_cnt++; if (mem_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL bst_rv_early got %b exp 0", mem_rvalid_o); end
    tick();
    vec_cnt++; if (mem_rvalid_o !== 1'b1) begin err_cnt++; $display("FAIL bst_rv got %b exp 1", mem_rvalid_o); end
    vec_cnt++; if (mem_busy_o !== 1'b0) begin err_cnt++; $display("FAIL bst_busy got %b exp 0", mem_busy_o); end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    tick();
    vec_cnt++; if (mem_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL bst_rv_pulse got %b exp 0", mem_rvalid_o); end
  endtask

  task automatic test_half_load(input logic sg, input logic [31:0] exp_data);
    set_req(1'b0, 2'b01, sg, 32'h0000_2002, 32'h0);
    data_rdata_i = 32'h8001_1234;
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if (data_be_o !== 4'b1100) begin err_cnt++; $display("FAIL hld_be got %b exp 1100", data_be_o); end
    tick(); tick();
    vec_cnt++; if (mem_rvalid_o !== 1'b1) begin err_cnt++; $display("FAIL hld_rv got %b exp 1", mem_rvalid_o); end
    vec_cnt++; if (mem_rdata_o !== exp_data) begin err_cnt++; $display("FAIL hld_data got %h exp %h", mem_rdata_o, exp_data); end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_gnt_stall();
    int pulses;
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'h1234_5678);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;  // rvalid in REQ must be ignored
    tick();
    mem_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) data_gnt_i = 1'b1;
      vec_cnt++; if ({data_req_o, mem_busy_o, mem_rvalid_o} !== 3'b110) begin err_cnt++; $display("FAIL stall_ctl[%0d] got %b exp 110", i, {data_req_o, mem_busy_o, mem_rvalid_o}); end
      vec_cnt++; if (data_addr_o !== 32'h0000_5004 || data_be_o !== 4'b1111) begin err_cnt++; $display("FAIL stall_addr[%0d] got %h/%b exp 00005004/1111", i, data_addr_o, data_be_o); end
      tick();
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    vec_cnt++; if ({data_req_o, mem_busy_o} !== 2'b01) begin err_cnt++; $display("FAIL stall_wait got %b exp 01", {data_req_o, mem_busy_o}); end
    tick();
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_rvalid_o === 1'b1) pulses++;
      tick();
    end
    vec_cnt++; if (pulses != 1) begin err_cnt++; $display("FAIL stall_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_misaligned();
    set_req(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if ({mem_misaligned_o, data_req_o, mem_busy_o} !== 3'b100) begin err_cnt++; $display("FAIL mis_word got %b exp 100", {mem_misaligned_o, data_req_o, mem_busy_o}); end
    tick();
    vec_cnt++; if ({mem_misaligned_o, data_req_o, mem_busy_o} !== 3'b000) begin err_cnt++; $display("FAIL mis_after got %b exp 000", {mem_misaligned_o, data_req_o, mem_busy_o}); end
    set_req(1'b0, 2'b01, 1'b0, 32'h0000_2003, 32'h0);
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if ({mem_misaligned_o, data_req_o} !== 2'b10) begin err_cnt++; $display("FAIL mis_half got %b exp 10", {mem_misaligned_o, data_req_o}); end
    tick();
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
    data_rdata_i = 32'h1122_3344; data_rvalid_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if ({mem_misaligned_o, data_req_o, data_be_o} !== 6'b01_0010) begin err_cnt++; $display("FAIL mis_byte_ok got %b exp 010010", {mem_misaligned_o, data_req_o, data_be_o}); end
    vec_cnt++; if (data_addr_o !== 32'h0000_3000) begin err_cnt++; $display("FAIL mis_byte_addr got %h exp 00003000", data_addr_o); end
    tick(); tick();
    vec_cnt++; if (mem_rdata_o !== 32'h0000_0033) begin err_cnt++; $display("FAIL mis_byte_data got %h exp 00000033", mem_rdata_o); end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_wait_rv();
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_6000, 32'h5555_AAAA);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if (data_we_o !== 1'b1) begin err_cnt++; $display("FAIL rwv_we got %b exp 1", data_we_o); end
    tick();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    vec_cnt++; if ({data_req_o, data_we_o, mem_busy_o, mem_rvalid_o, data_be_o} !== 8'h00) begin err_cnt++; $display("FAIL rwv_ctl got %b exp 00000000", {data_req_o, data_we_o, mem_busy_o, mem_rvalid_o, data_be_o}); end
    vec_cnt++; if (data_addr_o !== 32'h0 || data_wdata_o !== 32'h0 || mem_rdata_o !== 32'h0) begin err_cnt++; $display("FAIL rwv_data got %h/%h/%h exp 0/0/0", data_addr_o, data_wdata_o, mem_rdata_o); end
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
    vec_cnt++; if ({mem_rvalid_o, mem_busy_o} !== 2'b00) begin err_cnt++; $display("FAIL rwv_stray got %b exp 00", {mem_rvalid_o, mem_busy_o}); end
    set_req(1'b0, 2'b10, 1'b1, 32'h0000_6000, 32'h0);
    data_rdata_i = 32'h0000_00FF; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    tick(); tick();
    vec_cnt++; if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL rwv_next got %b/%h exp 1/ffffffff", mem_rvalid_o, mem_rdata_o); end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    set_req(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0);
    data_rdata_i = 32'hDEAD_BEEF; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    tick();
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_4008, 32'hCAFE_F00D);
    tick(); tick();
    vec_cnt++; if ({mem_rvalid_o, mem_busy_o} !== 2'b10 || mem_rdata_o !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL b2b_first got %b/%h exp 10/deadbeef", {mem_rvalid_o, mem_busy_o}, mem_rdata_o); end
    data_rdata_i = 32'h0000_0000;
    tick();
    mem_req_i = 1'b0;
    vec_cnt++; if ({data_req_o, data_we_o, mem_busy_o} !== 3'b111 || data_addr_o !== 32'h0000_4008) begin err_cnt++; $display("FAIL b2b_accept got %b/%h exp 111/00004008", {data_req_o, data_we_o, mem_busy_o}, data_addr_o); end
    tick(); tick();
    vec_cnt++; if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL b2b_retain got %b/%h exp 1/deadbeef", mem_rvalid_o, mem_rdata_o); end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_data_type_i = 2'b00;
    mem_sign_ext_i = 1'b0; mem_wdata_i = 32'h0; mem_addr_i = 32'h0;
    test_reset();
    test_byte_store();
    test_half_load(1'b1, 32'hFFFF_8001);
    test_half_load(1'b0, 32'h0000_8001);
    test_gnt_stall();
    test_misaligned();
    test_reset_wait_rv();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
